// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the board/piece collision logic.
//   - DEF_BOARD_W / DEF_BOARD_H / DEF_PIECE_N / DEF_POS_W : default geometry
//   - state_t   : collision checker FSM states (IDLE / SCAN / DONE)
//   - hit_t     : the four collision cause flags, packed
//   - static_idx: linear index of board cell (x, y) in the occupancy vector
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 20;
    localparam int DEF_PIECE_N = 4;
    localparam int DEF_POS_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic bottom;
        logic block;
    } hit_t;

    // Occupancy is stored row-major with row 0 at the board bottom.
    function automatic int static_idx(input int x, input int y, input int board_w);
        return y * board_w + x;
    endfunction

endpackage

// File: rtl/collision_checker_seq_if.sv
// -----------------------------------------------------------------------------
// collision_checker_seq_if
// Request/response bus of the sequential collision checker.
//
// Handshake: a transfer happens on a rising clk edge where the producer's
// *_valid and the consumer's *_ready are both high. The producer keeps its
// payload stable while valid is high; the checker holds resp_valid and the
// verdict (valid, hit_*) stable until resp_ready is seen.
//
// Signals:
//   req_valid / req_ready   request handshake (requester -> checker)
//   pos_x, pos_y            signed anchor = window top-right cell
//   float                   N*N pattern, bit r*N+c = window row r, column c
//   static_bits             board occupancy snapshot, bit y*BOARD_W+x
//   resp_valid / resp_ready response handshake (checker -> requester)
//   valid                   1 = no collision
//   hit_left/right/bottom/block  collision causes
//
// Modports: master = requester (game control FSM), slave = the checker.
// -----------------------------------------------------------------------------
interface collision_checker_seq_if #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int PIECE_N = 4,
    parameter int POS_W   = 6
);

    logic                         req_valid;
    logic                         req_ready;
    logic signed [POS_W-1:0]      pos_x;
    logic signed [POS_W-1:0]      pos_y;
    logic [PIECE_N*PIECE_N-1:0]   float;
    logic [BOARD_W*BOARD_H-1:0]   static_bits;
    logic                         resp_valid;
    logic                         resp_ready;
    logic                         valid;
    logic                         hit_left;
    logic                         hit_right;
    logic                         hit_bottom;
    logic                         hit_block;

    modport master (
        output req_valid, pos_x, pos_y, float, static_bits, resp_ready,
        input  req_ready, resp_valid, valid,
               hit_left, hit_right, hit_bottom, hit_block
    );

    modport slave (
        input  req_valid, pos_x, pos_y, float, static_bits, resp_ready,
        output req_ready, resp_valid, valid,
               hit_left, hit_right, hit_bottom, hit_block
    );

endinterface

// File: rtl/collision_row_eval.sv
// -----------------------------------------------------------------------------
// collision_row_eval
// Combinational check of one window row against the board.
//
// Ports:
//   row_bits_i  PIECE_N pattern bits of this row (bit c = window column c)
//   row_y_i     signed board row of this window row
//   anchor_x_i  signed anchor column (window top-right cell)
//   static_i    board occupancy snapshot, bit y*BOARD_W+x
//   hit_o       cause flags for this row
// -----------------------------------------------------------------------------
module collision_row_eval
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int PIECE_N = DEF_PIECE_N,
    parameter int POS_W   = DEF_POS_W
) (
    input  logic [PIECE_N-1:0]         row_bits_i,
    input  logic signed [POS_W:0]      row_y_i,
    input  logic signed [POS_W-1:0]    anchor_x_i,
    input  logic [BOARD_W*BOARD_H-1:0] static_i,
    output hit_t                       hit_o
);

    localparam int IDX_W = $clog2(BOARD_W * BOARD_H);

    always_comb begin
        int               xi;
        int               yi;
        logic [IDX_W-1:0] idx;
        hit_o = '0;
        xi    = 0;
        idx   = '0;
        // Coordinates are held in int, which is wider than POS_W+1, so the
        // arithmetic never wraps for any legal anchor.
        yi = int'(row_y_i);
        for (int c = 0; c < PIECE_N; c++) begin
            xi = int'(anchor_x_i) - (PIECE_N - 1) + c;
            if (row_bits_i[c]) begin
                if (xi < 0)        hit_o.left   = 1'b1;
                if (xi >= BOARD_W) hit_o.right  = 1'b1;
                if (yi < 0)        hit_o.bottom = 1'b1;
                // Only in-board cells index the snapshot; rows above the
                // board (spawn zone) are legal and never flagged.
                if (xi >= 0 && xi < BOARD_W && yi >= 0 && yi < BOARD_H) begin
                    idx = IDX_W'(static_idx(xi, yi, BOARD_W));
                    if (static_i[idx]) hit_o.block = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/collision_checker_seq.sv
// -----------------------------------------------------------------------------
// collision_checker_seq
// Multi-cycle piece/board collision check. Accepts one request (anchor,
// N x N pattern, board snapshot), scans one window row per clock and returns
// a registered verdict with per-cause flags.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (aborts a scan in flight)
//   bus          collision_checker_seq_if.slave request/response bus
//   state_dbg_o  current FSM state
//
// Timing: request accepted at edge t, resp_valid high from edge t+N+1.
// Row r is evaluated in the cycle after edge t+r and its flags are
// registered; the accumulated flags absorb that row one edge later.
//
// Build option: `define COLLISION_EARLY_EXIT_EN to leave SCAN at the end of
// the first cycle whose accumulated flags are non-zero (latency row+2, flags
// cover only the rows scanned). Undefined: full scan, fixed latency N+1.
// -----------------------------------------------------------------------------
module collision_checker_seq
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int PIECE_N = DEF_PIECE_N,
    parameter int POS_W   = DEF_POS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    collision_checker_seq_if.slave bus,
    output state_t                 state_dbg_o
);

    // Counter runs 0..PIECE_N: values 0..N-1 select a row, N is the drain
    // cycle in which the last row's registered flags are accumulated.
    localparam int CNT_W  = $clog2(PIECE_N + 1);
    localparam int ROWS_P = 2 ** CNT_W;

`ifdef COLLISION_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t                     state_q;
    logic                       req_ready_q;
    logic                       resp_valid_q;
    logic                       valid_q;
    hit_t                       hit_q;
    hit_t                       hit_d;
    hit_t                       row_hit_q;
    hit_t                       row_hit;
    logic [CNT_W-1:0]           cnt_q;
    logic signed [POS_W-1:0]    pos_x_q;
    logic signed [POS_W-1:0]    pos_y_q;
    logic [PIECE_N*PIECE_N-1:0] float_q;
    logic [BOARD_W*BOARD_H-1:0] static_q;
    logic signed [POS_W:0]      row_y;
    logic [PIECE_N-1:0]         float_rows [ROWS_P];

    // Pattern viewed as rows, padded with empty rows so the counter can
    // index it directly, including the drain value.
    for (genvar r = 0; r < ROWS_P; r++) begin : g_rows
        if (r < PIECE_N) begin : g_used
            assign float_rows[r] = float_q[r*PIECE_N +: PIECE_N];
        end else begin : g_pad
            assign float_rows[r] = '0;
        end
    end

    always_comb begin
        row_y = (POS_W+1)'(int'(pos_y_q) - (PIECE_N - 1) + int'(cnt_q));
    end

    collision_row_eval #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .PIECE_N (PIECE_N),
        .POS_W   (POS_W)
    ) u_row_eval (
        .row_bits_i (float_rows[cnt_q]),
        .row_y_i    (row_y),
        .anchor_x_i (pos_x_q),
        .static_i   (static_q),
        .hit_o      (row_hit)
    );

    always_comb begin
        hit_d = hit_t'(hit_q | row_hit_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            valid_q      <= 1'b1;
            hit_q        <= '0;
            row_hit_q    <= '0;
            cnt_q        <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            float_q      <= '0;
            static_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        pos_x_q     <= bus.pos_x;
                        pos_y_q     <= bus.pos_y;
                        float_q     <= bus.float;
                        static_q    <= bus.static_bits;
                        hit_q       <= '0;
                        row_hit_q   <= '0;
                        valid_q     <= 1'b1;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    hit_q     <= hit_d;
                    row_hit_q <= row_hit;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PIECE_N) || (EARLY_EXIT && hit_d != '0)) begin
                        valid_q      <= (hit_d == '0);
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.valid      = valid_q;
    assign bus.hit_left   = hit_q.left;
    assign bus.hit_right  = hit_q.right;
    assign bus.hit_bottom = hit_q.bottom;
    assign bus.hit_block  = hit_q.block;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_collision_checker_seq.sv
// -----------------------------------------------------------------------------
// tb_collision_checker_seq
// Directed test of collision_checker_seq with hand-computed expectations.
// Cell coordinates: x = pos_x - 3 + c, y = pos_y - 3 + r (N = 4).
// The O-piece pattern 16'h0066 occupies (r,c) = (0,1),(0,2),(1,1),(1,2),
// i.e. columns pos_x-2, pos_x-1 and rows pos_y-3, pos_y-2.
// -----------------------------------------------------------------------------
module tb_collision_checker_seq;
    import tetris_pkg::*;

    localparam int BW = 10;
    localparam int BH = 20;
    localparam int N  = 4;
    localparam int PW = 6;

    localparam logic [15:0] O_PIECE = 16'h0066;

`ifdef COLLISION_EARLY_EXIT_EN
    localparam int EXIT_LAT = 2;   // hit already in row 0
`else
    localparam int EXIT_LAT = 5;
`endif
    localparam int FULL_LAT = 5;

    logic   clk = 1'b0;
    logic   rst;
    state_t state_dbg;

    int total = 0;
    int bad   = 0;

    collision_checker_seq_if #(.BOARD_W(BW), .BOARD_H(BH), .PIECE_N(N), .POS_W(PW)) bus ();

    collision_checker_seq #(.BOARD_W(BW), .BOARD_H(BH), .PIECE_N(N), .POS_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.hit_left, bus.hit_right, bus.hit_bottom, bus.hit_block};
    endfunction

    // Waits for resp_valid after an accept edge; returns edges counted.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_resp(input string tag);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check({tag, ".resp_valid_off"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ".req_ready_on"}, 32'(bus.req_ready), 32'd1);
    endtask

    // flags order: {left, right, bottom, block}
    task automatic run_req(input string tag, input int px, input int py,
                           input logic [15:0] fl, input logic [199:0] st,
                           input int exp_lat, input logic exp_valid,
                           input logic [3:0] exp_flags);
        int lat;
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.pos_x       = PW'(px);
        bus.pos_y       = PW'(py);
        bus.float       = fl;
        bus.static_bits = st;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".valid"}, 32'(bus.valid), 32'(exp_valid));
        check({tag, ".flags"}, 32'(flags()), 32'(exp_flags));
        check({tag, ".state"}, 32'(state_dbg), 32'(DONE));
        release_resp(tag);
    endtask

    initial begin
        logic [199:0] board;
        int           lat;

        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.resp_ready  = 1'b0;
        bus.pos_x       = '0;
        bus.pos_y       = '0;
        bus.float       = '0;
        bus.static_bits = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.req_ready", 32'(bus.req_ready), 32'd1);
        check("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset.valid", 32'(bus.valid), 32'd1);
        check("reset.flags", 32'(flags()), 32'd0);
        check("reset.state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // Cells x 3,4 / y 7,8: inside, empty board.
        run_req("base", 5, 10, O_PIECE, '0, FULL_LAT, 1'b1, 4'b0000);
        // x -1,0 -> left wall.
        run_req("left", 1, 10, O_PIECE, '0, EXIT_LAT, 1'b0, 4'b1000);
        // x 8,9 -> touches the right edge, still legal.
        run_req("right_edge", 10, 10, O_PIECE, '0, FULL_LAT, 1'b1, 4'b0000);
        // x 9,10 -> right wall.
        run_req("right", 11, 10, O_PIECE, '0, EXIT_LAT, 1'b0, 4'b0100);
        // y -2,-1 -> floor.
        run_req("bottom", 5, 1, O_PIECE, '0, EXIT_LAT, 1'b0, 4'b0010);
        // y 17,18 -> legal near top.
        run_req("top", 5, 20, O_PIECE, '0, FULL_LAT, 1'b1, 4'b0000);
        // y 19,20 -> row 20 is spawn zone, legal.
        run_req("spawn", 5, 22, O_PIECE, '0, FULL_LAT, 1'b1, 4'b0000);
        // x -1,0 / y -2,-1 -> left and bottom together.
        run_req("multi", 1, 1, O_PIECE, '0, EXIT_LAT, 1'b0, 4'b1010);
        // Empty pattern never collides, even with a full board off-anchor.
        run_req("empty", 0, 0, 16'h0000, '1, FULL_LAT, 1'b1, 4'b0000);

        // Cells x 3,4 / y 10,11; bit 103 = (x3,y10) occupied.
        board      = '0;
        board[103] = 1'b1;
        run_req("block", 5, 13, O_PIECE, board, EXIT_LAT, 1'b0, 4'b0001);
        // Neighbours of the piece only: no false hit.
        board      = '0;
        board[102] = 1'b1;
        board[105] = 1'b1;
        board[112] = 1'b1;
        board[115] = 1'b1;
        board[93]  = 1'b1;
        board[123] = 1'b1;
        run_req("no_false_hit", 5, 13, O_PIECE, board, FULL_LAT, 1'b1, 4'b0000);
        // Single cell (r3,c3) at the anchor (9,19) = bit 199, last row scanned.
        board      = '0;
        board[199] = 1'b1;
        run_req("corner_hi", 9, 19, 16'h8000, board, FULL_LAT, 1'b0, 4'b0001);
        // Single cell (r0,c0) at (0,0) = bit 0.
        board    = '0;
        board[0] = 1'b1;
        run_req("corner_lo", 3, 3, 16'h0001, board, EXIT_LAT, 1'b0, 4'b0001);

        // Inputs changed during SCAN must be ignored (snapshot taken at accept).
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.pos_x       = PW'(5);
        bus.pos_y       = PW'(10);
        bus.float       = O_PIECE;
        bus.static_bits = '0;
        @(posedge clk);
        #1;
        bus.req_valid   = 1'b0;
        bus.pos_x       = PW'(1);
        bus.pos_y       = PW'(1);
        bus.static_bits = '1;
        check("snapshot.req_ready_low", 32'(bus.req_ready), 32'd0);
        wait_resp(lat);
        check("snapshot.latency", 32'(lat), 32'(FULL_LAT));
        check("snapshot.valid", 32'(bus.valid), 32'd1);
        check("snapshot.flags", 32'(flags()), 32'd0);
        release_resp("snapshot");

        // Stall: response held while resp_ready=0, new request not taken.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.pos_x       = PW'(1);
        bus.pos_y       = PW'(10);
        bus.float       = O_PIECE;
        bus.static_bits = '0;
        @(posedge clk);
        #1;
        bus.pos_x = PW'(5);   // a legal request stays offered during the stall
        wait_resp(lat);
        check("stall.latency", 32'(lat), 32'(EXIT_LAT));
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("stall.resp_valid", 32'(bus.resp_valid), 32'd1);
            check("stall.req_ready", 32'(bus.req_ready), 32'd0);
            check("stall.valid", 32'(bus.valid), 32'd0);
            check("stall.flags", 32'(flags()), 32'(4'b1000));
        end
        bus.req_valid = 1'b0;
        release_resp("stall");

        // Reset in the middle of a scan aborts the request.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.pos_x       = PW'(1);
        bus.pos_y       = PW'(1);
        bus.float       = O_PIECE;
        bus.static_bits = '0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midscan.state", 32'(state_dbg), 32'(SCAN));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midscan_rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("midscan_rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midscan_rst.valid", 32'(bus.valid), 32'd1);
        check("midscan_rst.flags", 32'(flags()), 32'd0);
        check("midscan_rst.state", 32'(state_dbg), 32'(IDLE));

        // Checker is usable again after the abort.
        run_req("after_rst", 5, 10, O_PIECE, '0, FULL_LAT, 1'b1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
